// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response bundle for alu_share_arbiter.
// The arbiter attaches through the slave modport; requesters, ALU and consumer through master.
interface alu_share_arbiter_if #(
  parameter int REGISTER_FILE_LEN = 32,
  parameter int EXEC_COMMAND_LEN  = 4,
  parameter int STATUS_REG_LEN    = 4
);
  logic                         req0_valid;
  logic                         req0_ready;
  logic [REGISTER_FILE_LEN-1:0] req0_val_1;
  logic [REGISTER_FILE_LEN-1:0] req0_val_2;
  logic [EXEC_COMMAND_LEN-1:0]  req0_exec_cmd;
  logic                         req0_s;

  logic                         req1_valid;
  logic                         req1_ready;
  logic [REGISTER_FILE_LEN-1:0] req1_val_1;
  logic [REGISTER_FILE_LEN-1:0] req1_val_2;
  logic [EXEC_COMMAND_LEN-1:0]  req1_exec_cmd;
  logic                         req1_s;

  logic [REGISTER_FILE_LEN-1:0] alu_val_1;
  logic [REGISTER_FILE_LEN-1:0] alu_val_2;
  logic [EXEC_COMMAND_LEN-1:0]  alu_exec_cmd;
  logic                         alu_carry_in;
  logic [REGISTER_FILE_LEN-1:0] alu_res;
  logic [STATUS_REG_LEN-1:0]    alu_status;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic                         rsp_id;
  logic [REGISTER_FILE_LEN-1:0] rsp_res;
  logic [STATUS_REG_LEN-1:0]    rsp_status;

  logic [STATUS_REG_LEN-1:0]    status_reg;

  modport master (
    output req0_valid, req0_val_1, req0_val_2, req0_exec_cmd, req0_s,
    input  req0_ready,
    output req1_valid, req1_val_1, req1_val_2, req1_exec_cmd, req1_s,
    input  req1_ready,
    input  alu_val_1, alu_val_2, alu_exec_cmd, alu_carry_in,
    output alu_res, alu_status,
    input  rsp_valid, rsp_id, rsp_res, rsp_status,
    output rsp_ready,
    input  status_reg
  );

  modport slave (
    input  req0_valid, req0_val_1, req0_val_2, req0_exec_cmd, req0_s,
    output req0_ready,
    input  req1_valid, req1_val_1, req1_val_2, req1_exec_cmd, req1_s,
    output req1_ready,
    output alu_val_1, alu_val_2, alu_exec_cmd, alu_carry_in,
    input  alu_res, alu_status,
    output rsp_valid, rsp_id, rsp_res, rsp_status,
    input  rsp_ready,
    output status_reg
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU; each operation walks IDLE -> EXEC -> RESP.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module alu_share_arbiter #(
  parameter int REGISTER_FILE_LEN = 32,
  parameter int EXEC_COMMAND_LEN  = 4,
  parameter int STATUS_REG_LEN    = 4
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                   state_reg, state_next;
  logic [1:0]                   valid_vec, grant_vec;
  logic                         accept;
  logic                         id_reg, s_reg;
  logic [REGISTER_FILE_LEN-1:0] val_1_reg, val_2_reg, rsp_res_reg;
  logic [EXEC_COMMAND_LEN-1:0]  cmd_reg;
  logic                         carry_reg;
  logic                         rsp_id_reg;
  logic [STATUS_REG_LEN-1:0]    rsp_status_reg, flags_reg;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_vec = 2'b00;
    if (state_reg == IDLE && !rst) begin
      grant_vec = (valid_vec == 2'b11) ? 2'b01 : valid_vec;
    end
  end
`else
  // Index of the requester granted most recently; 1 after reset so requester 0 wins first.
  logic last_reg;

  always_comb begin
    grant_vec = 2'b00;
    if (state_reg == IDLE && !rst) begin
      if (valid_vec == 2'b11) grant_vec = last_reg ? 2'b01 : 2'b10;
      else                    grant_vec = valid_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last_reg <= 1'b1;
    else if (accept) last_reg <= grant_vec[1];
  end
`endif

  assign accept         = |grant_vec;
  assign bus.req0_ready = grant_vec[0];
  assign bus.req1_ready = grant_vec[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      id_reg         <= 1'b0;
      s_reg          <= 1'b0;
      val_1_reg      <= '0;
      val_2_reg      <= '0;
      cmd_reg        <= '0;
      carry_reg      <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_res_reg    <= '0;
      rsp_status_reg <= '0;
      flags_reg      <= '0;
    end else begin
      state_reg <= state_next;
      // Only the granted requester's payload is sampled.
      if (accept) begin
        id_reg    <= grant_vec[1];
        s_reg     <= grant_vec[1] ? bus.req1_s        : bus.req0_s;
        val_1_reg <= grant_vec[1] ? bus.req1_val_1    : bus.req0_val_1;
        val_2_reg <= grant_vec[1] ? bus.req1_val_2    : bus.req0_val_2;
        cmd_reg   <= grant_vec[1] ? bus.req1_exec_cmd : bus.req0_exec_cmd;
        carry_reg <= flags_reg[2];
      end
      if (state_reg == EXEC) begin
        rsp_res_reg    <= bus.alu_res;
        rsp_status_reg <= bus.alu_status;
        rsp_id_reg     <= id_reg;
        if (s_reg) flags_reg <= bus.alu_status;
      end
    end
  end

  assign bus.alu_val_1    = val_1_reg;
  assign bus.alu_val_2    = val_2_reg;
  assign bus.alu_exec_cmd = cmd_reg;
  assign bus.alu_carry_in = carry_reg;
  assign bus.rsp_valid    = (state_reg == RESP);
  assign bus.rsp_id       = rsp_id_reg;
  assign bus.rsp_res      = rsp_res_reg;
  assign bus.rsp_status   = rsp_status_reg;
  assign bus.status_reg   = flags_reg;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, transaction-level arbitration model,
// directed scenarios followed by randomized traffic.
module tb_alu_share_arbiter;
  localparam int RL = 32;
  localparam int CL = 4;
  localparam int SL = 4;
  localparam logic [3:0] EXEC_ADD = 4'd0;
  localparam logic [3:0] EXEC_ADC = 4'd1;
  localparam logic [3:0] EXEC_SUB = 4'd2;
  localparam logic [3:0] EXEC_AND = 4'd3;
  localparam logic [3:0] EXEC_OR  = 4'd4;
  localparam logic [3:0] EXEC_XOR = 4'd5;

  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  cmd;
    logic        s;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.REGISTER_FILE_LEN(RL), .EXEC_COMMAND_LEN(CL), .STATUS_REG_LEN(SL)) bus ();
  alu_share_arbiter #(.REGISTER_FILE_LEN(RL), .EXEC_COMMAND_LEN(CL), .STATUS_REG_LEN(SL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int   errors = 0;
  int   checks = 0;
  op_t  q0[$];
  op_t  q1[$];
  int   grants[$];
  logic [3:0] m_status;
  bit   m_last;

  // Returns {Z,C,N,V,result}; undefined commands give a fixed marker value.
  function automatic logic [35:0] alu_fn(logic [3:0] cmd, logic [31:0] a, logic [31:0] b, logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 32'h0;
    case (cmd)
      EXEC_ADD: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      EXEC_ADC: begin
        w = {1'b0, a} + {1'b0, b} + {32'd0, cin}; r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      EXEC_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      EXEC_AND: r = a & b;
      EXEC_OR:  r = a | b;
      EXEC_XOR: r = a ^ b;
      default:  return {4'b0101, 32'hDEADBEEF};
    endcase
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  always_comb begin
    {bus.alu_status, bus.alu_res} = alu_fn(bus.alu_exec_cmd, bus.alu_val_1, bus.alu_val_2, bus.alu_carry_in);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present queue head when pending, otherwise idle with garbage payload.
  task automatic drive_req(input int n);
    op_t op;
    bit  pend;
    pend = (n == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (pend) op = (n == 0) ? q0[0] : q1[0];
    else      op = {$urandom, $urandom, 4'($urandom), 1'($urandom)};
    if (n == 0) begin
      bus.req0_valid = pend; bus.req0_val_1 = op.v1; bus.req0_val_2 = op.v2;
      bus.req0_exec_cmd = op.cmd; bus.req0_s = op.s;
    end else begin
      bus.req1_valid = pend; bus.req1_val_1 = op.v1; bus.req1_val_2 = op.v2;
      bus.req1_exec_cmd = op.cmd; bus.req1_s = op.s;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 0);
    check({tag, "_rsp_id"},     32'(bus.rsp_id), 0);
    check({tag, "_rsp_res"},    bus.rsp_res, 0);
    check({tag, "_rsp_status"}, 32'(bus.rsp_status), 0);
    check({tag, "_status_reg"}, 32'(bus.status_reg), 0);
    check({tag, "_alu_val_1"},  bus.alu_val_1, 0);
    check({tag, "_alu_val_2"},  bus.alu_val_2, 0);
    check({tag, "_alu_cmd"},    32'(bus.alu_exec_cmd), 0);
    check({tag, "_alu_cin"},    32'(bus.alu_carry_in), 0);
  endtask

  // Called at a negedge; holds rst for one edge and checks outputs while rst is still high.
  task automatic do_reset();
    rst = 1'b1; drive_req(0); drive_req(1);
    @(negedge clk); #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 0);
    check("rst_req1_ready", 32'(bus.req1_ready), 0);
    check_reset_state("rst");
    rst = 1'b0;
    m_status = 4'd0; m_last = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE and at least one queue non-empty.
  task automatic step_op(input int stall);
    int          g;
    op_t         op;
    logic [35:0] exp;
    logic        cin;
    bit          v0, v1;
    drive_req(0); drive_req(1); #1;
    v0 = (q0.size() != 0); v1 = (q1.size() != 0);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = m_last ? 0 : 1;
`endif
    end else g = v0 ? 0 : 1;
    check("idle_rsp_valid",  32'(bus.rsp_valid), 0);
    check("idle_req0_ready", 32'(bus.req0_ready), 32'(g == 0));
    check("idle_req1_ready", 32'(bus.req1_ready), 32'(g == 1));
    if (g == 0) op = q0.pop_front(); else op = q1.pop_front();
    cin = m_status[2];
    exp = alu_fn(op.cmd, op.v1, op.v2, cin);
    m_last = (g == 1);
    grants.push_back(g);
    if (op.s) m_status = exp[35:32];

    @(negedge clk); drive_req(0); drive_req(1); #1;
    check("exec_req0_ready", 32'(bus.req0_ready), 0);
    check("exec_req1_ready", 32'(bus.req1_ready), 0);
    check("exec_rsp_valid",  32'(bus.rsp_valid), 0);
    check("exec_alu_val_1",  bus.alu_val_1, op.v1);
    check("exec_alu_val_2",  bus.alu_val_2, op.v2);
    check("exec_alu_cmd",    32'(bus.alu_exec_cmd), 32'(op.cmd));
    check("exec_alu_cin",    32'(bus.alu_carry_in), 32'(cin));

    @(negedge clk); bus.rsp_ready = (stall == 0); #1;
    check("resp_rsp_valid",  32'(bus.rsp_valid), 1);
    check("resp_rsp_id",     32'(bus.rsp_id), 32'(g));
    check("resp_rsp_res",    bus.rsp_res, exp[31:0]);
    check("resp_rsp_status", 32'(bus.rsp_status), 32'(exp[35:32]));
    check("resp_status_reg", 32'(bus.status_reg), 32'(m_status));
    check("resp_req0_ready", 32'(bus.req0_ready), 0);
    check("resp_req1_ready", 32'(bus.req1_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (i == stall - 1) bus.rsp_ready = 1'b1;
      #1;
      check("stall_rsp_valid",  32'(bus.rsp_valid), 1);
      check("stall_rsp_res",    bus.rsp_res, exp[31:0]);
      check("stall_rsp_id",     32'(bus.rsp_id), 32'(g));
      check("stall_rsp_status", 32'(bus.rsp_status), 32'(exp[35:32]));
      check("stall_ready_or",   32'(bus.req0_ready | bus.req1_ready), 0);
    end
    @(negedge clk);
    $display("op grant=%0d cmd=%0d a=%08h b=%08h cin=%0d res=%08h st=%04b stall=%0d",
             g, op.cmd, op.v1, op.v2, cin, exp[31:0], m_status, stall);
  endtask

  function automatic op_t rand_op();
    op_t op;
    op.v1  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
    op.v2  = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
    op.cmd = 4'($urandom_range(0, 7));
    op.s   = 1'($urandom);
    return op;
  endfunction

  initial begin
    int exp_order[4];
    bus.rsp_ready = 1'b1;
    m_status = 4'd0; m_last = 1'b1;

    // Reset with req0 pending, then single ADD 5+7 with s=1.
    q0.push_back('{32'd5, 32'd7, EXEC_ADD, 1'b1});
    @(negedge clk);
    do_reset();
    step_op(0);

    // req1 SUB 3-3 with s=0: Z set in rsp_status, architectural flags untouched.
    q1.push_back('{32'd3, 32'd3, EXEC_SUB, 1'b0});
    step_op(0);
    check("sub_status_reg_unchanged", 32'(bus.status_reg), 0);

    // Carry chain: ADD sets C and Z, ADC consumes the carry.
    q0.push_back('{32'hFFFFFFFF, 32'd1, EXEC_ADD, 1'b1});
    step_op(0);
    check("add_carry_status_reg", 32'(bus.status_reg), 32'(4'b1100));
    q0.push_back('{32'd0, 32'd0, EXEC_ADC, 1'b0});
    step_op(0);
    check("adc_result", bus.rsp_res, 32'd1);

    // Consumer stalls four cycles while req0 keeps a request pending.
    q1.push_back('{32'h0F0F0F0F, 32'h00FF00FF, EXEC_XOR, 1'b0});
    q0.push_back('{32'd9, 32'd4, EXEC_OR, 1'b0});
    step_op(4);
    step_op(0);

    // Reset asserted in EXEC aborts the operation and clears the flags.
    q0.push_back('{32'd1, 32'd2, EXEC_ADD, 1'b1});
    drive_req(0); drive_req(1); #1;
    check("abort_idle_req0_ready", 32'(bus.req0_ready), 1);
    @(negedge clk);
    rst = 1'b1; #1;
    check("abort_rst_req0_ready", 32'(bus.req0_ready), 0);
    @(negedge clk); #1;
    check("abort_rst_hold_ready", 32'(bus.req0_ready), 0);
    check_reset_state("abort");
    rst = 1'b0;
    m_status = 4'd0; m_last = 1'b1;
    step_op(0);

    // Both requesters valid from reset, two operations each.
    q0.push_back('{32'd10, 32'd1, EXEC_ADD, 1'b0});
    q0.push_back('{32'd20, 32'd2, EXEC_SUB, 1'b0});
    q1.push_back('{32'd30, 32'd3, EXEC_AND, 1'b0});
    q1.push_back('{32'd40, 32'd4, EXEC_OR,  1'b0});
    @(negedge clk);
    do_reset();
    grants.delete();
    for (int i = 0; i < 4; i++) step_op(0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) check("both_valid_grant_order", 32'(grants[i]), 32'(exp_order[i]));

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(rand_op());
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(rand_op());
      if (q0.size() == 0 && q1.size() == 0) q1.push_back(rand_op());
      step_op(int'($urandom_range(0, 2)));
    end
    while (q0.size() != 0 || q1.size() != 0) step_op(0);
    drive_req(0); drive_req(1); #1;
    check("final_rsp_valid", 32'(bus.rsp_valid), 0);
    check("final_status_reg", 32'(bus.status_reg), 32'(m_status));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL provide, per requester n in {0,1}: reqn_valid input 1 (request present); reqn_ready output 1 (request accepted this cycle); reqn_val_1 input REGISTER_FILE_LEN (operand 1); reqn_val_2 input REGISTER_FILE_LEN (operand 2); reqn_exec_cmd input EXEC_COMMAND_LEN (ALU command); reqn_s input 1 (update status register).
REQ-003 The block SHALL drive the shared ALU through: alu_val_1 output REGISTER_FILE_LEN; alu_val_2 output REGISTER_FILE_LEN; alu_exec_cmd output EXEC_COMMAND_LEN; alu_carry_in output 1; alu_res input REGISTER_FILE_LEN; alu_status input STATUS_REG_LEN, ordered {Z,C,N,V}.
REQ-004 The block SHALL return results through: rsp_valid output 1 (response present); rsp_ready input 1 (consumer accepts); rsp_id output 1 (requester index); rsp_res output REGISTER_FILE_LEN (captured result); rsp_status output STATUS_REG_LEN (captured ALU flags).
REQ-005 The block SHALL expose status_reg output STATUS_REG_LEN, the architectural {Z,C,N,V} flags.

Function
REQ-006 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-007 In IDLE, reqn_ready SHALL be 1 only for the granted requester n with reqn_valid=1; in EXEC and RESP both readies SHALL be 0.
REQ-008 Accept = valid&ready; on accept the block SHALL latch operands, command, s bit, requester id and carry_in=status_reg[2], then enter EXEC.
REQ-009 In EXEC, alu_* outputs SHALL present the latched values; at the end of EXEC the block SHALL capture alu_res and alu_status into rsp_res/rsp_status and enter RESP.
REQ-010 Outside EXEC, alu_* outputs SHALL hold the last latched values (no toggling while idle).
REQ-011 rsp_valid SHALL be 1 exactly in RESP; rsp_res, rsp_status and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-012 On rsp_valid&rsp_ready the block SHALL return to IDLE; a new accept SHALL be possible on the following cycle (minimum 3 cycles per operation, accept-to-rsp_valid latency 2 cycles).
REQ-013 If the latched s bit is 1, status_reg SHALL load alu_status at the EXEC-to-RESP edge; otherwise status_reg SHALL be unchanged.
REQ-014 Default arbitration SHALL be round-robin: with both valid in IDLE, the requester not granted last SHALL win; with one valid, that requester SHALL win.
REQ-015 The last-granted pointer SHALL update only on accept.
REQ-016 Requesters SHALL hold valid and payload until accepted; the block SHALL not depend on payload of a non-granted requester.
REQ-017 A command value outside the defined EXEC set SHALL still complete the handshake; rsp_res is then don't-care and status_reg SHALL follow REQ-013.

Reset
REQ-018 On rst=1 at a clock edge the block SHALL enter IDLE and set status_reg=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_status=0, all alu_* outputs=0, last-granted pointer=1 (requester 0 wins first).
REQ-019 Reset asserted in EXEC or RESP SHALL abort the operation: no response delivered, no status_reg update.
REQ-020 reqn_ready SHALL be 0 during any cycle with rst=1.

Configuration
REQ-021 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both are valid and the pointer SHALL be unused; without it, REQ-014 round-robin SHALL apply.

Verification
REQ-022 Single req0 EXEC_ADD val_1=5, val_2=7, s=1 -> req0_ready cycle k, rsp_valid cycle k+2, rsp_res=12, rsp_id=0, status_reg=0000.
REQ-023 Both valid from reset, two ops each, rsp_ready=1 -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN order 0,0,1,1.
REQ-024 req1 EXEC_SUB val_1=3, val_2=3, s=0 -> rsp_res=0, rsp_status Z=1, status_reg unchanged.
REQ-025 EXEC_ADD 0xFFFFFFFF+1, s=1, then EXEC_ADC 0+0 -> first status_reg C=1,Z=1; second alu_carry_in=1, rsp_res=1.
REQ-026 rsp_ready=0 for 4 cycles in RESP -> rsp_valid/res/id stable, both readies 0; rst pulse in EXEC -> IDLE, no rsp_valid, status_reg=0.
